// File: rtl/icache_fill_responder_if.sv
// Line-fill bus between the ICache, this responder and the memory arbiter.
// slave  : the responder side (icache_fill_responder).
// master : the environment side (cache request + memory return path).
interface icache_fill_responder_if #(
  parameter int ADDR_W = 64,
  parameter int BEAT_W = 64,
  parameter int LINE_W = 512
);
  // cache side
  logic              irequest;
  logic [ADDR_W-1:0] iaddr;
  logic [LINE_W-1:0] idata;
  logic              idone;
  // memory side
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [BEAT_W-1:0] mem_rdata;

  modport slave (
    input  irequest, iaddr, mem_ready, mem_rvalid, mem_rdata,
    output idata, idone, mem_req, mem_addr
  );

  modport master (
    output irequest, iaddr, mem_ready, mem_rvalid, mem_rdata,
    input  idata, idone, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_fill_responder.sv
// icache_fill_responder
//   Takes a one-cycle line request, issues one burst read, collects
//   LINE_W/BEAT_W beats into a line register and pulses idone for one cycle.
//   FSM: IDLE -> ISSUE -> BEATS -> DONE -> IDLE.
//
// Optional feature macro: ICACHE_FILL_LINEBUF_EN
//   When defined, a tag/valid pair remembers the address of the line
//   currently held in idata; a repeat request for that address skips the
//   memory burst and goes straight to DONE.
module icache_fill_responder #(
  parameter int ADDR_W = 64,
  parameter int BEAT_W = 64,
  parameter int LINE_W = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  icache_fill_responder_if.slave   io
);

  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int BCNT_W = $clog2(BEATS);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BEATS = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                         state_q, state_d;
  logic [BCNT_W-1:0]              beat_q,  beat_d;
  logic [ADDR_W-1:0]              addr_q,  addr_d;
  logic [BEATS-1:0][BEAT_W-1:0]   line_q;
  logic                           beat_wr;
  logic                           lb_hit;

`ifdef ICACHE_FILL_LINEBUF_EN
  logic [ADDR_W-1:0]              tag_q, tag_d;
  logic                           lbv_q, lbv_d;

  // Repeat request for the line already sitting in idata.
  assign lb_hit = lbv_q && (io.iaddr == tag_q);
`else
  assign lb_hit = 1'b0;
`endif

  // A beat is only captured while collecting; stray beats in other states
  // (e.g. late returns after a reset abandoned a fill) are dropped here.
  assign beat_wr = (state_q == S_BEATS) && io.mem_rvalid;

  // Next-state, beat counter and address latch; outputs decoded from state.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    io.mem_req  = 1'b0;
    io.idone    = 1'b0;
`ifdef ICACHE_FILL_LINEBUF_EN
    tag_d       = tag_q;
    lbv_d       = lbv_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (io.irequest) begin
          addr_d  = io.iaddr;
          state_d = lb_hit ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        io.mem_req = 1'b1;
        if (io.mem_ready) state_d = S_BEATS;
      end
      S_BEATS: begin
        if (io.mem_rvalid) begin
          beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = S_DONE;
        end
      end
      S_DONE: begin
        io.idone = 1'b1;
`ifdef ICACHE_FILL_LINEBUF_EN
        tag_d    = addr_q;
        lbv_d    = 1'b1;
`endif
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register; reset abandons any fill in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
    end
  end

`ifdef ICACHE_FILL_LINEBUF_EN
  // Last-line tag; valid cleared on reset because idata is cleared too.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= '0;
      lbv_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      lbv_q <= lbv_d;
    end
  end
`endif

  // Line assembly: beat k lands in slot k; slots keep their value between
  // fills so idata stays stable after idone (and serves as the line buffer).
  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= '0;
    end else if (beat_wr) begin
      line_q[beat_q] <= io.mem_rdata;
    end
  end

  assign io.idata    = line_q;
  assign io.mem_addr = addr_q;

`ifndef SYNTHESIS
  // Protocol misuse by the requester or the memory side stops simulation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (io.irequest && (io.iaddr[OFF_W-1:0] != '0))
        $fatal(1, "icache_fill_responder: misaligned iaddr %h", io.iaddr);
      if (io.irequest && (state_q != S_IDLE))
        $fatal(1, "icache_fill_responder: irequest while busy");
      if (io.mem_rvalid && (state_q == S_ISSUE))
        $fatal(1, "icache_fill_responder: mem_rvalid before burst accepted");
    end
  end
`endif

endmodule

// File: tb/tb_icache_fill_responder.sv
// Scoreboard bench for icache_fill_responder.
// The driver plays both the ICache and the memory; for every request it
// pushes the expected line, idone cycle and mem_req duration derived from
// the chosen ready delay and beat gaps. A separate monitor pops on idone.
module tb_icache_fill_responder;
  localparam int ADDR_W = 64;
  localparam int BEAT_W = 64;
  localparam int LINE_W = 512;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icache_fill_responder_if #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .LINE_W(LINE_W)) bus ();

  icache_fill_responder #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .LINE_W(LINE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  typedef struct {
    logic [63:0]  addr;
    logic [511:0] line;
    int           done_cyc;
    int           req_cycles;
  } exp_t;

  exp_t         sbq[$];
  logic [63:0]  memw [logic [63:0]];
  logic [511:0] last_line = '0;
  logic [63:0]  lb_tag = '0;
  bit           lb_valid = 1'b0;
  int           req_cnt = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Backing store: word at a byte address, created randomly on first touch.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (!memw.exists(a)) memw[a] = {$urandom, $urandom};
    return memw[a];
  endfunction

  // Monitor: counts mem_req cycles, checks mem_addr, scores each idone.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        req_cnt = 0;
      end else begin
        if (bus.mem_req) begin
          req_cnt++;
          if (sbq.size() > 0) check("mem_addr", bus.mem_addr, sbq[0].addr);
        end
        if (bus.idone) begin
          if (sbq.size() == 0) begin
            check("unexpected_idone", 1'b1, 1'b0);
          end else begin
            e = sbq.pop_front();
            check("idata", bus.idata, e.line);
            check("idone_cycle", cyc, e.done_cyc);
            check("mem_req_cycles", req_cnt, e.req_cycles);
          end
          req_cnt = 0;
        end
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 64; i++) begin
      if (bus.idone) return;
      @(negedge clk);
    end
    check("idone_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    lb_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One complete request; gaps[3k+:3] idle cycles precede beat k.
  task automatic do_fill(input logic [63:0] addr, input int rdy, input logic [23:0] gaps);
    exp_t e;
    int   t;
    int   gsum;
    bit   hit;
    gsum = 0;
`ifdef ICACHE_FILL_LINEBUF_EN
    hit = lb_valid && (lb_tag == addr);
`else
    hit = 1'b0;
`endif
    @(negedge clk);
    t = cyc;
    bus.irequest = 1'b1;
    bus.iaddr    = addr;
    e.addr = addr;
    if (hit) begin
      e.line       = last_line;
      e.done_cyc   = t + 1;
      e.req_cycles = 0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        e.line[64*k +: 64] = mem_word(addr + 64'(8*k));
        gsum += int'(gaps[3*k +: 3]);
      end
      e.done_cyc   = t + 10 + rdy + gsum;
      e.req_cycles = rdy + 1;
    end
    sbq.push_back(e);
    @(negedge clk);
    bus.irequest = 1'b0;
    if (!hit) begin
      for (int w = 0; w <= rdy; w++) begin
        bus.mem_ready = (w == rdy);
        @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
        repeat (int'(gaps[3*k +: 3])) begin
          bus.mem_rvalid = 1'b0;
          @(negedge clk);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mem_word(addr + 64'(8*k));
        @(negedge clk);
      end
      bus.mem_rvalid = 1'b0;
    end
    wait_done();
    last_line = e.line;
    lb_valid  = 1'b1;
    lb_tag    = addr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  a;
    logic [23:0]  g;
    bus.irequest   = 1'b0;
    bus.iaddr      = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_idone", bus.idone, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_idata", bus.idata, '0);
    check("rst_mem_addr", bus.mem_addr, '0);

    // Single fill, beats 0..7 back-to-back, ready on first ask
    for (int k = 0; k < 8; k++) memw[64'h1000 + 64'(8*k)] = 64'(k);
    do_fill(64'h1000, 0, 24'd0);

    // Backpressure: ready low 5 cycles, 2-cycle gap before beat 3
    do_fill(64'h1040, 5, 24'(2) << 9);

    // Back-to-back request in the cycle after idone
    do_fill(64'h1080, 0, 24'd0);

    // Reset during beat 4 abandons the fill; stray beats ignored
    @(negedge clk);
    bus.irequest = 1'b1;
    bus.iaddr    = 64'h1100;
    @(negedge clk);
    bus.irequest  = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = {$urandom, $urandom};
      @(negedge clk);
    end
    reset = 1'b1;
    lb_valid = 1'b0;
    bus.mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = {$urandom, $urandom};
      @(negedge clk);
    end
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check("abandon_idata", bus.idata, '0);
    check("abandon_mem_req", bus.mem_req, 1'b0);
    last_line = '0;
    do_fill(64'h2040, 1, 24'd0);

    // Reset and irequest together: request dropped
    @(negedge clk);
    reset = 1'b1;
    lb_valid = 1'b0;
    bus.irequest = 1'b1;
    bus.iaddr    = 64'h5000;
    @(negedge clk);
    reset = 1'b0;
    bus.irequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_req_dropped", bus.mem_req, 1'b0);
    end
    last_line = '0;

    // Line buffer behaviour (plain burst when feature is off)
    do_fill(64'h3000, 0, 24'd0);
    do_fill(64'h3000, 0, 24'd0);
    do_fill(64'h3040, 2, 24'o01020301);
    do_reset();
    last_line = '0;
    do_fill(64'h3040, 0, 24'd0);

    // Randomized fills over a small address set so repeats occur
    for (int n = 0; n < 24; n++) begin
      a = 64'h4000 + 64'(64 * $urandom_range(0, 2));
      g = '0;
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, 3) == 0) g[3*k +: 3] = 3'($urandom_range(1, 2));
      do_fill(a, $urandom_range(0, 3), g);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
